pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-003 SHALL have parameter ZERO_REG_EXEMPT, default 1; 1 = register 0 never causes a hazard or forward.
REQ-004 SHALL have ports in this order, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_use_rs, id_use_rt  in  1  ID reads that source
- id_branch, id_br_ne  in  1  ID is BEQ (br_ne=0) or BNE (br_ne=1)
- id_jump  in  1  ID is an unconditional jump
- id_eq  in  1  forwarded operand equality from the ID comparator
- ex_regwr, ex_memtoreg  in  1  EX writes a register / EX is a load
- ex_rd  in  REG_AW  EX destination
- mem_regwr, mem_memtoreg  in  1  MEM writes a register / MEM is a load
- mem_rd  in  REG_AW  MEM destination
- wb_regwr  in  1  WB writes a register
- wb_rd  in  REG_AW  WB destination
- cnt_clr  in  1  synchronous clear of the performance counters
- pc_stall, if_id_stall  out  1  hold PC and IF/ID
- id_ex_bubble  out  1  zero ID/EX control
- if_id_flush  out  1  kill the IF/ID instruction
- redirect  out  1  PC takes the branch/jump target
- fwd_a, fwd_b  out  2  ID comparator source for rs/rt: 0 regfile, 1 EX/MEM, 2 MEM/WB
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Function
REQ-005 SHALL define match(x,d) = (x==d) and not (ZERO_REG_EXEMPT and d==0); source rs counts only with id_use_rs, rt only with id_use_rt.
REQ-006 SHALL compute the required stall length N when id_valid=1 and the stall counter is 0, as the maximum of:
- 2 if id_branch, ex_memtoreg and EX matches a used source
- 1 if id_branch, ex_regwr, not ex_memtoreg, and EX matches
- 1 if id_branch, mem_memtoreg and MEM matches
- 1 if not id_branch, ex_memtoreg and EX matches (load-use)
- otherwise 0
REQ-007 SHALL hold a 2-bit stall counter: when N>0, load N-1; when the counter is nonzero, decrement it and ignore new detection.
REQ-008 SHALL assert stall = (N>0) or (counter != 0); pc_stall = if_id_stall = id_ex_bubble = stall, combinationally in the same cycle.
REQ-009 SHALL set take = id_valid and ((id_branch and (id_eq xor id_br_ne)) or id_jump).
REQ-010 SHALL set redirect = if_id_flush = take and not stall, so a stall defers the branch or jump until the cycle it resolves.
REQ-011 SHALL select fwd_x for each source:
- 1 if mem_regwr, not mem_memtoreg, and MEM matches
- else 2 if wb_regwr and WB matches
- else 0
- EX/MEM has priority over MEM/WB.
REQ-012 SHALL increment stall_cnt on every stall cycle and flush_cnt on every if_id_flush cycle; both saturate at all-ones; cnt_clr has priority and loads 0.
REQ-013 SHALL keep all outputs 0 while id_valid=0, except the counter-driven stall during the remainder of a loaded stall and the performance counters.

Reset
REQ-014 SHALL, while rst_n=0, clear the stall counter, stall_cnt and flush_cnt asynchronously.
REQ-015 SHALL, when rst_n is asserted mid-stall, drop all stall outputs immediately; the first cycle after release performs fresh detection.

Structure
REQ-016 SHALL place the fwd encodings (FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2) and the stall-length constants in a shared package, pipe_ctrl_pkg.
REQ-017 SHALL implement the two saturating counters as one instantiated sub-module, sat_counter, instantiated twice.

Verification
REQ-018 Load-use: EX lw to $8; ID add using $8 -> 1 stall cycle with bubble; next cycle no stall; stall_cnt=1.
REQ-019 Branch on a load: EX lw to $9; ID beq $9,$10 -> stall 2 cycles; third cycle fwd_a=2; with id_eq=1, redirect=1 and if_id_flush=1 for 1 cycle; flush_cnt=1.
REQ-020 Zero register: EX lw to $0; ID uses $0 -> no stall with ZERO_REG_EXEMPT=1; 1-cycle stall with ZERO_REG_EXEMPT=0.
REQ-021 Priority and deferral: MEM alu-writes $3 and WB writes $3 -> fwd_a=1; jump during an active stall -> redirect only after stall=0.
REQ-022 Reset and counters: assert rst_n=0 during a 2-cycle stall -> stall outputs 0 at once and counters 0; force stall_cnt to saturate -> holds all-ones; cnt_clr -> 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the ID-stage hazard controller: comparator forwarding
// selects and the stall lengths the detector can request.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller for a 5-stage pipeline with branches resolved in
// ID: detects load-use and branch-operand stalls, picks comparator forwarding,
// redirects on taken branches/jumps and counts stall and flush cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int CNT_W           = 16,
    parameter int ZERO_REG_EXEMPT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_br_ne,
    input  logic              id_jump,
    input  logic              id_eq,
    input  logic              ex_regwr,
    input  logic              ex_memtoreg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_regwr,
    input  logic              mem_memtoreg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              cnt_clr,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              redirect,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // A source matches a destination unless the destination is the hardwired zero register.
    function automatic logic match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] d);
        return (x == d) && !((ZERO_REG_EXEMPT != 0) && (d == '0));
    endfunction

    // EX/MEM (ALU result) beats MEM/WB; a load in MEM has no data yet for the comparator.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_AW-1:0] src,
        input logic              use_src,
        input logic              m_regwr,
        input logic              m_memtoreg,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_regwr,
        input logic [REG_AW-1:0] w_rd
    );
        if (use_src && m_regwr && !m_memtoreg && match(src, m_rd)) begin
            return FWD_EXMEM;
        end else if (use_src && w_regwr && match(src, w_rd)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    logic       ex_hit;
    logic       mem_hit;
    logic [1:0] need;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       stall;
    logic       take;

    // Does any source actually read the register being produced in EX / MEM?
    always_comb begin
        ex_hit  = (id_use_rs && match(id_rs, ex_rd))  || (id_use_rt && match(id_rt, ex_rd));
        mem_hit = (id_use_rs && match(id_rs, mem_rd)) || (id_use_rt && match(id_rt, mem_rd));
    end

    // Fresh detection only when no earlier stall is still draining; longest requirement wins.
    always_comb begin
        need = STALL_NONE;
        if (id_valid && (cnt_q == 2'd0)) begin
            if (id_branch && ex_memtoreg && ex_hit) begin
                need = STALL_TWO;
            end else if (id_branch && ex_regwr && !ex_memtoreg && ex_hit) begin
                need = STALL_ONE;
            end else if (id_branch && mem_memtoreg && mem_hit) begin
                need = STALL_ONE;
            end else if (!id_branch && ex_memtoreg && ex_hit) begin
                need = STALL_ONE;
            end
        end
    end

    // The current cycle is the first stall cycle, so only the remainder is loaded.
    always_comb begin
        cnt_d = 2'd0;
        if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end else if (need != STALL_NONE) begin
            cnt_d = need - 2'd1;
        end
    end

    // Remaining stall cycles after this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Outputs are gated by rst_n so a reset mid-stall releases the pipe at once.
    always_comb begin
        stall        = rst_n && ((need != STALL_NONE) || (cnt_q != 2'd0));
        take         = id_valid && ((id_branch && (id_eq ^ id_br_ne)) || id_jump);
        pc_stall     = stall;
        if_id_stall  = stall;
        id_ex_bubble = stall;
        redirect     = rst_n && take && !stall;
        if_id_flush  = redirect;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        if (rst_n && id_valid) begin
            fwd_a = fwd_pick(id_rs, id_use_rs, mem_regwr, mem_memtoreg, mem_rd, wb_regwr, wb_rd);
            fwd_b = fwd_pick(id_rt, id_use_rt, mem_regwr, mem_memtoreg, mem_rd, wb_regwr, wb_rd);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule
